matrix_add_sub: RTL and testbench

MATRIX_ADD_SUB -- requirements
Module: matrix_add_sub

---
 rtl/matrix_add_sub_pkg.sv | 29 ++
 rtl/matrix_add_sub_row_add_sub.sv | 43 ++++
 rtl/matrix_add_sub.sv | 135 +++++++++++++
 tb/tb_matrix_add_sub.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_add_sub_pkg.sv
// -----------------------------------------------------------------------------
// matrix_add_sub_pkg
// Shared definitions for the matrix add/subtract block:
//   MAT_DIM  - matrix rows/cols
//   ELEM_W   - element width (two's complement)
//   BUS_W    - full operand/result bus width (MAT_DIM*MAT_DIM*ELEM_W = 256)
//   ROW_W    - width of one matrix row on the bus
//   state_t  - controller FSM state encoding
//   elemLsb  - bit position of element (r,c) on a bus
// -----------------------------------------------------------------------------
package matrix_add_sub_pkg;

   localparam int MAT_DIM = 4;
   localparam int ELEM_W  = 16;
   localparam int BUS_W   = MAT_DIM * MAT_DIM * ELEM_W;
   localparam int ROW_W   = MAT_DIM * ELEM_W;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      DONE    = 2'd2
   } state_t;

   // Element (r,c) lives at bits [elemLsb(r,c) +: w]; row r starts at elemLsb(r,0).
   function automatic int elemLsb(input int r, input int c, input int dim, input int w);
      return (r * dim + c) * w;
   endfunction

endpackage

// File: rtl/matrix_add_sub_row_add_sub.sv
// -----------------------------------------------------------------------------
// row_add_sub
// Purely combinational LANES-wide add/subtract of one matrix row.
// Arithmetic wraps modulo 2^ELEM_W; a per-lane flag reports signed overflow.
// Ports:
//   aRow, bRow  in   LANES*ELEM_W  operand rows, lane l at [l*ELEM_W +: ELEM_W]
//   add1sub0    in   1             1 = aRow + bRow, 0 = aRow - bRow
//   resRow      out  LANES*ELEM_W  wrapped result row
//   laneOvf     out  LANES         signed overflow per lane
// -----------------------------------------------------------------------------
module row_add_sub #(
   parameter int LANES  = 4,
   parameter int ELEM_W = 16
) (
   input  logic [LANES*ELEM_W-1:0] aRow,
   input  logic [LANES*ELEM_W-1:0] bRow,
   input  logic                    add1sub0,
   output logic [LANES*ELEM_W-1:0] resRow,
   output logic [LANES-1:0]        laneOvf
);

   localparam int MSB = ELEM_W - 1;

   for (genvar l = 0; l < LANES; l++) begin : gLane
      logic [ELEM_W-1:0] a;
      logic [ELEM_W-1:0] b;
      logic [ELEM_W-1:0] r;

      assign a = aRow[l*ELEM_W +: ELEM_W];
      assign b = bRow[l*ELEM_W +: ELEM_W];
      assign r = add1sub0 ? (a + b) : (a - b);

      assign resRow[l*ELEM_W +: ELEM_W] = r;

      // Add overflows when both operands share a sign the result lacks.
      // Subtract overflows when operand signs differ and the result sign
      // differs from the minuend.
      assign laneOvf[l] = add1sub0
                        ? ((a[MSB] == b[MSB]) && (r[MSB] != a[MSB]))
                        : ((a[MSB] != b[MSB]) && (r[MSB] != a[MSB]));
   end

endmodule

// File: rtl/matrix_add_sub.sv
// -----------------------------------------------------------------------------
// matrix_add_sub
// Element-wise add or subtract of two MAT_DIM x MAT_DIM matrices A and B.
// Operands are loaded over dataIn, then a start request walks the rows, one
// row per cycle, through a single shared row_add_sub datapath.
//
// Handshake (en/rw strobe, no ready): en is sampled on every rising edge.
// In IDLE, en=1 with rw=1 loads dataIn into A (matDecide=0) or B
// (matDecide=1); en=1 with rw=0 starts an operation using add1sub0
// (1 = A+B, 0 = A-B). Requests outside IDLE are dropped. Completion is
// signalled by a one-cycle fleg pulse; dataOut is valid from that cycle on.
//
// Ports:
//   clk        in   1      rising-edge clock
//   RESET      in   1      asynchronous active-low reset
//   dataIn     in   BUS    operand bus, element (r,c) at [(r*MAT_DIM+c)*ELEM_W +: ELEM_W]
//   en         in   1      request strobe
//   rw         in   1      1 = load operand, 0 = start operation
//   matDecide  in   1      load target: 0 = A, 1 = B
//   add1sub0   in   1      operation at start: 1 = add, 0 = subtract
//   dataOut    out  BUS    result matrix (same layout as dataIn)
//   fleg       out  1      one-cycle completion pulse
//   busy       out  1      operation in progress
//   ovf        out  1      sticky signed overflow of the last operation
//   dbgState   out  2      current FSM state, for observation only
// -----------------------------------------------------------------------------
module matrix_add_sub #(
   parameter int MAT_DIM = matrix_add_sub_pkg::MAT_DIM,
   parameter int ELEM_W  = matrix_add_sub_pkg::ELEM_W
) (
   input  logic                               clk,
   input  logic                               RESET,
   input  logic [MAT_DIM*MAT_DIM*ELEM_W-1:0]  dataIn,
   input  logic                               en,
   input  logic                               rw,
   input  logic                               matDecide,
   input  logic                               add1sub0,
   output logic [MAT_DIM*MAT_DIM*ELEM_W-1:0]  dataOut,
   output logic                               fleg,
   output logic                               busy,
   output logic                               ovf,
   output matrix_add_sub_pkg::state_t         dbgState
);

   import matrix_add_sub_pkg::*;

   localparam int BUS_WL = MAT_DIM * MAT_DIM * ELEM_W;
   localparam int ROW_WL = MAT_DIM * ELEM_W;
   localparam int CNT_W  = (MAT_DIM > 1) ? $clog2(MAT_DIM) : 1;
   localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(MAT_DIM - 1);

   state_t            state;
   logic [BUS_WL-1:0] matA;
   logic [BUS_WL-1:0] matB;
   logic [BUS_WL-1:0] result;
   logic [CNT_W-1:0]  rowCnt;
   logic              opAdd;     // operation captured at start, immune to later add1sub0 changes

   int                rowLsb;
   logic [ROW_WL-1:0] aRow;
   logic [ROW_WL-1:0] bRow;
   logic [ROW_WL-1:0] resRow;
   logic [MAT_DIM-1:0] laneOvf;

   // Row currently being processed, selected from both operand registers.
   assign rowLsb = elemLsb(int'(rowCnt), 0, MAT_DIM, ELEM_W);
   assign aRow   = matA[rowLsb +: ROW_WL];
   assign bRow   = matB[rowLsb +: ROW_WL];

   row_add_sub #(
      .LANES  (MAT_DIM),
      .ELEM_W (ELEM_W)
   ) uRowAddSub (
      .aRow     (aRow),
      .bRow     (bRow),
      .add1sub0 (opAdd),
      .resRow   (resRow),
      .laneOvf  (laneOvf)
   );

   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         state  <= IDLE;
         matA   <= '0;
         matB   <= '0;
         result <= '0;
         rowCnt <= '0;
         opAdd  <= 1'b0;
         fleg   <= 1'b0;
         busy   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         fleg <= 1'b0;
         case (state)
            IDLE: begin
               if (en) begin
                  if (rw) begin
                     if (matDecide) matB <= dataIn;
                     else           matA <= dataIn;
                  end else begin
                     opAdd  <= add1sub0;
                     ovf    <= 1'b0;
                     rowCnt <= '0;
                     busy   <= 1'b1;
                     state  <= COMPUTE;
                  end
               end
            end

            COMPUTE: begin
               // Rows land one at a time; dataOut therefore shows the previous
               // result until row 0 of the new one is written.
               result[rowLsb +: ROW_WL] <= resRow;
               if (|laneOvf) ovf <= 1'b1;
               if (rowCnt == LAST_ROW) begin
                  rowCnt <= '0;
                  busy   <= 1'b0;
                  fleg   <= 1'b1;
                  state  <= DONE;
               end else begin
                  rowCnt <= rowCnt + 1'b1;
               end
            end

            DONE: state <= IDLE;

            default: state <= IDLE;
         endcase
      end
   end

   assign dataOut  = result;
   assign dbgState = state;

endmodule

// File: tb/tb_matrix_add_sub.sv
// Bench for matrix_add_sub: random and directed matrix add/subtract with a
// scoreboard fed at issue time and drained by a fleg-triggered monitor.
module tb_matrix_add_sub;
   import matrix_add_sub_pkg::*;

   logic         clk = 1'b0;
   logic         RESET;
   logic [255:0] dataIn;
   logic         en;
   logic         rw;
   logic         matDecide;
   logic         add1sub0;
   logic [255:0] dataOut;
   logic         fleg;
   logic         busy;
   logic         ovf;
   state_t       dbgState;

   int tests = 0;
   int fails = 0;

   logic [255:0] exp_q[$];
   logic         exp_ovf_q[$];

   // Reference copies of the operand matrices, element i = r*4+c.
   logic [15:0] mA[16];
   logic [15:0] mB[16];

   matrix_add_sub dut (
      .clk       (clk),
      .RESET     (RESET),
      .dataIn    (dataIn),
      .en        (en),
      .rw        (rw),
      .matDecide (matDecide),
      .add1sub0  (add1sub0),
      .dataOut   (dataOut),
      .fleg      (fleg),
      .busy      (busy),
      .ovf       (ovf),
      .dbgState  (dbgState)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- check helpers ----------------
   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkInt(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   task automatic modelResult(input bit add, output logic [255:0] res, output logic o);
      int sa, sb, r;
      res = '0;
      o   = 1'b0;
      for (int i = 0; i < 16; i++) begin
         sa = int'($signed(mA[i]));
         sb = int'($signed(mB[i]));
         r  = add ? sa + sb : sa - sb;
         if (r > 32767 || r < -32768) o = 1'b1;
         res[i*16 +: 16] = r[15:0];
      end
   endtask

   function automatic logic [255:0] fill(input logic [15:0] v);
      return {16{v}};
   endfunction

   function automatic logic [255:0] randMat();
      logic [255:0] m;
      int pick;
      for (int i = 0; i < 16; i++) begin
         pick = int'($urandom_range(0, 3));
         m[i*16 +: 16] = (pick == 0) ? 16'h7FFF : (pick == 1) ? 16'h8000 : 16'($urandom);
      end
      return m;
   endfunction

   // ---------------- drivers ----------------
   task automatic loadMat(input bit sel, input logic [255:0] val);
      @(negedge clk);
      en = 1'b1; rw = 1'b1; matDecide = sel; dataIn = val;
      @(negedge clk);
      en = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (sel) mB[i] = val[i*16 +: 16];
         else     mA[i] = val[i*16 +: 16];
      end
   endtask

   // Start an operation and watch its timing for 8 cycles. Optionally try a
   // B load and a second start while it runs; both must be dropped.
   task automatic runOp(input bit add, input bit injectLoad, input bit injectStart);
      logic [255:0] e;
      logic eo;
      int busyCnt, flegCnt, flegK;
      modelResult(add, e, eo);
      exp_q.push_back(e);
      exp_ovf_q.push_back(eo);
      @(negedge clk);
      en = 1'b1; rw = 1'b0; add1sub0 = add;
      @(negedge clk);
      busyCnt = 0; flegCnt = 0; flegK = 0;
      add1sub0 = ~add;
      for (int k = 1; k <= 8; k++) begin
         if (busy === 1'b1) busyCnt++;
         if (fleg === 1'b1) begin
            flegCnt++;
            if (flegK == 0) flegK = k;
         end
         en = 1'b0;
         if (k == 2 && injectLoad) begin
            en = 1'b1; rw = 1'b1; matDecide = 1'b1; dataIn = fill(16'hFFFF);
         end
         if (k == 3 && injectStart) begin
            en = 1'b1; rw = 1'b0; add1sub0 = ~add;
         end
         @(negedge clk);
      end
      en = 1'b0;
      checkInt("fleg_latency", flegK, 5);
      checkInt("fleg_width", flegCnt, 1);
      checkInt("busy_cycles", busyCnt, 4);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [255:0] e;
      logic eo;
      if (RESET === 1'b1 && fleg === 1'b1) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_fleg: got fleg=1 expected no completion");
         end else begin
            e  = exp_q.pop_front();
            eo = exp_ovf_q.pop_front();
            check("result", dataOut, e);
            checkInt("ovf", 32'(ovf), 32'(eo));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [255:0] m;
      RESET = 1'b0; en = 1'b0; rw = 1'b0; matDecide = 1'b0; add1sub0 = 1'b0; dataIn = '0;
      for (int i = 0; i < 16; i++) begin mA[i] = '0; mB[i] = '0; end

      #1;
      check("reset_dataOut", dataOut, '0);
      checkInt("reset_busy", 32'(busy), 0);
      checkInt("reset_fleg", 32'(fleg), 0);
      checkInt("reset_ovf", 32'(ovf), 0);
      checkInt("reset_state", 32'(dbgState), 32'(IDLE));

      @(negedge clk); @(negedge clk);
      RESET = 1'b1;

      // No load yet: operands are zero.
      runOp(1'b1, 1'b0, 1'b0);

      // 3 + 1 and 3 - 1 on every element.
      loadMat(1'b0, fill(16'h0003));
      loadMat(1'b1, fill(16'h0001));
      runOp(1'b1, 1'b0, 1'b0);
      runOp(1'b0, 1'b0, 1'b1);

      // Single-lane overflow at element (2,1).
      m = fill(16'h0003);
      m[(2*4+1)*16 +: 16] = 16'h7FFF;
      loadMat(1'b0, m);
      runOp(1'b1, 1'b0, 1'b0);

      // 0 - 1 wraps without overflow.
      loadMat(1'b0, fill(16'h0000));
      runOp(1'b0, 1'b0, 1'b0);

      // Load during COMPUTE is dropped, then a real reload is used.
      runOp(1'b1, 1'b1, 1'b0);
      loadMat(1'b1, fill(16'hFFFF));
      runOp(1'b1, 1'b0, 1'b0);

      // Reset in the second COMPUTE cycle aborts without completion.
      loadMat(1'b0, fill(16'h1234));
      loadMat(1'b1, fill(16'h0101));
      @(negedge clk);
      en = 1'b1; rw = 1'b0; add1sub0 = 1'b1;
      @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      RESET = 1'b0;
      #1;
      check("abort_dataOut", dataOut, '0);
      checkInt("abort_busy", 32'(busy), 0);
      checkInt("abort_ovf", 32'(ovf), 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkInt("abort_no_fleg", 32'(fleg), 0);
      end
      RESET = 1'b1;
      for (int i = 0; i < 16; i++) begin mA[i] = '0; mB[i] = '0; end
      loadMat(1'b0, fill(16'h1234));
      loadMat(1'b1, fill(16'h0101));
      runOp(1'b0, 1'b0, 1'b0);

      // Random operations, sometimes reusing an operand.
      for (int n = 0; n < 12; n++) begin
         int which;
         which = int'($urandom_range(0, 3));
         if (which == 0 || which == 2) loadMat(1'b0, randMat());
         if (which == 1 || which == 2) loadMat(1'b1, randMat());
         runOp(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      repeat (3) @(negedge clk);
      checkInt("scoreboard_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
